// File: rtl/hms_alarm_watch.sv
`default_nettype none
// ============================================================================
//  Module   : hms_alarm_watch
//  Purpose  : Hours/minutes/seconds watch with tick prescaler, 12/24-hour
//             display conversion and a settable alarm with timed ring and
//             acknowledge. Controlled by stop_run/next/inc/dec user pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module hms_alarm_watch #(
    parameter int TICKS_PER_SEC = 1,
    parameter int RING_SECS     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stop_run,
    input  logic       next,
    input  logic       inc,
    input  logic       dec,
    input  logic       mode12,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       pm,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       alarm_ring,
    output logic       running,
    output logic [2:0] field
);

    localparam int               c_pre_w     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICKS_PER_SEC - 1);
    localparam logic [7:0]       c_ring_last = 8'(RING_SECS - 1);

    localparam logic [2:0] c_fld_sec  = 3'd0;
    localparam logic [2:0] c_fld_min  = 3'd1;
    localparam logic [2:0] c_fld_hr   = 3'd2;
    localparam logic [2:0] c_fld_amin = 3'd3;
    localparam logic [2:0] c_fld_ahr  = 3'd4;

    typedef enum logic [0:0] {
        ST_SET = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_pre_w-1:0] r_pre;
    logic [5:0]         r_sec, r_min, r_amin;
    logic [4:0]         r_hr, r_ahr;
    logic [2:0]         r_field;
    logic               r_ring;
    logic [7:0]         r_ring_cnt;

    logic [5:0] w_sec_nxt, w_min_nxt, w_amin_nxt;
    logic [4:0] w_hr_nxt, w_ahr_nxt;
    logic       w_tick, w_edit, w_adv, w_chg, w_match;

    // Wrap-around step within 0..59 (up or down)
    function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // Wrap-around step within 0..23 (up or down)
    function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
        if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    // stop_run wins over edits; next wins over inc/dec; inc+dec cancel
    assign w_tick = (r_state == ST_RUN) && (r_pre == c_pre_last);
    assign w_edit = (r_state == ST_SET) && !stop_run;
    assign w_adv  = w_edit && next;
    assign w_chg  = w_edit && !next && (inc ^ dec);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_SET;
        else     r_state <= w_state_nxt;
    end

    // Next-state: stop_run toggles between SET and RUN
    always_comb begin
        w_state_nxt = r_state;
        if (stop_run) w_state_nxt = (r_state == ST_SET) ? ST_RUN : ST_SET;
    end

    // Prescaler: cleared on every entry to RUN, free-runs while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_pre <= '0;
        else if (r_state == ST_SET) begin
            if (stop_run)         r_pre <= '0;
        end
        else if (w_tick)          r_pre <= '0;
        else                      r_pre <= r_pre + 1'b1;
    end

    // Next time/alarm values: carry chain on tick, single-field edit in SET
    always_comb begin
        w_sec_nxt  = r_sec;
        w_min_nxt  = r_min;
        w_hr_nxt   = r_hr;
        w_amin_nxt = r_amin;
        w_ahr_nxt  = r_ahr;
        if (w_tick) begin
            if (r_sec == 6'd59) begin
                w_sec_nxt = 6'd0;
                if (r_min == 6'd59) begin
                    w_min_nxt = 6'd0;
                    w_hr_nxt  = step24(r_hr, 1'b1);
                end else begin
                    w_min_nxt = r_min + 6'd1;
                end
            end else begin
                w_sec_nxt = r_sec + 6'd1;
            end
        end else if (w_chg) begin
            case (r_field)
                c_fld_sec:  w_sec_nxt  = step60(r_sec, inc);
                c_fld_min:  w_min_nxt  = step60(r_min, inc);
                c_fld_hr:   w_hr_nxt   = step24(r_hr, inc);
                c_fld_amin: w_amin_nxt = step60(r_amin, inc);
                c_fld_ahr:  w_ahr_nxt  = step24(r_ahr, inc);
                default:    ;
            endcase
        end
    end

    // Only a running tick can trigger; SET edits landing on the alarm do not
    assign w_match = w_tick && alarm_en && (w_sec_nxt == 6'd0) &&
                     (w_min_nxt == r_amin) && (w_hr_nxt == r_ahr);

    // Time, alarm setting and edit-field registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec   <= '0;
            r_min   <= '0;
            r_hr    <= '0;
            r_amin  <= '0;
            r_ahr   <= '0;
            r_field <= c_fld_sec;
        end else begin
            r_sec  <= w_sec_nxt;
            r_min  <= w_min_nxt;
            r_hr   <= w_hr_nxt;
            r_amin <= w_amin_nxt;
            r_ahr  <= w_ahr_nxt;
            if (w_adv) r_field <= (r_field == c_fld_ahr) ? c_fld_sec : r_field + 3'd1;
        end
    end

    // Alarm ring: clear beats (re)trigger, timed out after RING_SECS ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (alarm_ack || !alarm_en) begin
            r_ring <= 1'b0;
        end else if (w_match) begin
            r_ring     <= 1'b1;
            r_ring_cnt <= '0;
        end else if (r_ring && w_tick) begin
            r_ring_cnt <= r_ring_cnt + 8'd1;
            if (r_ring_cnt == c_ring_last) r_ring <= 1'b0;
        end
    end

    // 12/24-hour display conversion from the internal 24-hour value
    always_comb begin
        hours = r_hr;
        if (mode12) begin
            if (r_hr == 5'd0)       hours = 5'd12;
            else if (r_hr > 5'd12)  hours = r_hr - 5'd12;
        end
    end

    assign pm            = (r_hr >= 5'd12);
    assign minutes       = r_min;
    assign seconds       = r_sec;
    assign alarm_hours   = r_ahr;
    assign alarm_minutes = r_amin;
    assign alarm_ring    = r_ring;
    assign running       = (r_state == ST_RUN);
    assign field         = r_field;

endmodule
`default_nettype wire

// File: tb/tb_hms_alarm_watch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_hms_alarm_watch
//  Purpose  : Self-checking bench for hms_alarm_watch (directed scenarios plus
//             randomized pulses against a seconds-of-day reference model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hms_alarm_watch;

    localparam int RING = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stop_run = 0, next = 0, inc = 0, dec = 0;
    logic mode12 = 0, alarm_en = 0, alarm_ack = 0;

    logic [4:0] hours, alarm_hours, hours_4, alarm_hours_4;
    logic [5:0] minutes, seconds, alarm_minutes, minutes_4, seconds_4, alarm_minutes_4;
    logic       pm, alarm_ring, running, pm_4, alarm_ring_4, running_4;
    logic [2:0] field, field_4;

    int checks = 0;
    int failures = 0;

    // Reference model state (one-second-per-cycle instance)
    bit m_run;
    int m_field, m_tod, m_al, m_ring, m_cnt, m_pre;

    hms_alarm_watch #(.TICKS_PER_SEC(1), .RING_SECS(RING)) dut (
        .clk(clk), .rst(rst), .stop_run(stop_run), .next(next), .inc(inc), .dec(dec),
        .mode12(mode12), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .alarm_ring(alarm_ring), .running(running), .field(field)
    );

    hms_alarm_watch #(.TICKS_PER_SEC(4), .RING_SECS(60)) dut4 (
        .clk(clk), .rst(rst), .stop_run(stop_run), .next(next), .inc(inc), .dec(dec),
        .mode12(mode12), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .hours(hours_4), .minutes(minutes_4), .seconds(seconds_4), .pm(pm_4),
        .alarm_hours(alarm_hours_4), .alarm_minutes(alarm_minutes_4),
        .alarm_ring(alarm_ring_4), .running(running_4), .field(field_4)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_run = 0; m_field = 0; m_tod = 0; m_al = 0; m_ring = 0; m_cnt = 0; m_pre = 0;
    endfunction

    // Behavioural update for one clock edge: time kept as seconds of day,
    // alarm as minutes of day
    function automatic void model_edge(bit sr, bit nx, bit up, bit dn, bit ack);
        bit tick;
        int nt, h, m, s, d;
        tick = m_run && (m_pre == 0);
        nt = tick ? (m_tod + 1) % 86400 : m_tod;
        if (ack || !alarm_en)              m_ring = 0;
        else if (tick && nt == m_al * 60) begin m_ring = 1; m_cnt = 0; end
        else if (m_ring && tick) begin
            m_cnt++;
            if (m_cnt >= RING) m_ring = 0;
        end
        m_pre = 0;
        if (!m_run && !sr) begin
            d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
            if (nx) m_field = (m_field + 1) % 5;
            else if (d != 0) begin
                h = nt / 3600; m = (nt / 60) % 60; s = nt % 60;
                case (m_field)
                    0: s = (s + d + 60) % 60;
                    1: m = (m + d + 60) % 60;
                    2: h = (h + d + 24) % 24;
                    3: m_al = (m_al / 60) * 60 + ((m_al % 60) + d + 60) % 60;
                    default: m_al = (((m_al / 60) + d + 24) % 24) * 60 + m_al % 60;
                endcase
                nt = h * 3600 + m * 60 + s;
            end
        end
        m_tod = nt;
        if (sr) m_run = !m_run;
    endfunction

    function automatic int disp_h(int h, logic m12);
        if (!m12)  return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    // One clock: apply pulses, clock them in, update model, release pulses
    task automatic step(input bit sr, input bit nx, input bit up, input bit dn, input bit ack);
        stop_run = sr; next = nx; inc = up; dec = dn; alarm_ack = ack;
        @(posedge clk);
        model_edge(sr, nx, up, dn, ack);
        #1;
        stop_run = 0; next = 0; inc = 0; dec = 0; alarm_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1; stop_run = 0; next = 0; inc = 0; dec = 0; alarm_ack = 0;
        model_reset();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        mode12 = 0; #1;
        checks++; if ({hours, minutes, seconds} !== 17'd0) begin failures++; $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", hours, minutes, seconds); end
        checks++; if ({alarm_hours, alarm_minutes, alarm_ring, pm} !== 13'd0) begin failures++; $display("FAIL reset_alarm: got ah=%0d am=%0d ring=%0b pm=%0b expected all 0", alarm_hours, alarm_minutes, alarm_ring, pm); end
        checks++; if ({running, field} !== 4'd0) begin failures++; $display("FAIL reset_state: got running=%0b field=%0d expected 0/0", running, field); end
        mode12 = 1; #1;
        checks++; if (hours !== 5'd12 || pm !== 1'b0) begin failures++; $display("FAIL reset_mode12: got hours=%0d pm=%0b expected 12/0", hours, pm); end
        mode12 = 0;
    endtask

    task automatic test_count_carry();
        do_reset(); alarm_en = 0;
        step(1, 0, 0, 0, 0);
        repeat (3661) step(0, 0, 0, 0, 0);
        checks++; if ({hours, minutes, seconds} !== {5'd1, 6'd1, 6'd1} || running !== 1'b1) begin failures++; $display("FAIL count_carry: got %0d:%0d:%0d run=%0b expected 1:1:1 run=1", hours, minutes, seconds, running); end
        // the stop_run cycle is still a RUN cycle, so its tick lands (01:01:02)
        step(1, 0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0, 0);
        checks++; if ({hours, minutes, seconds} !== {5'd1, 6'd1, 6'd2} || running !== 1'b0) begin failures++; $display("FAIL hold_in_set: got %0d:%0d:%0d run=%0b expected 1:1:2 run=0", hours, minutes, seconds, running); end
    endtask

    task automatic test_edit_wrap();
        do_reset();
        step(0, 0, 0, 1, 0);
        checks++; if (seconds !== 6'd59 || minutes !== 6'd0) begin failures++; $display("FAIL edit_sec_dec: got sec=%0d min=%0d expected 59/0", seconds, minutes); end
        repeat (2) step(0, 1, 0, 0, 0);
        repeat (21) step(0, 0, 1, 0, 0);
        checks++; if (hours !== 5'd21 || field !== 3'd2) begin failures++; $display("FAIL edit_hr_set: got hours=%0d field=%0d expected 21/2", hours, field); end
        repeat (5) step(0, 0, 1, 0, 0);
        checks++; if (hours !== 5'd2 || minutes !== 6'd0 || seconds !== 6'd59) begin failures++; $display("FAIL edit_hr_wrap: got %0d:%0d:%0d expected 2:0:59", hours, minutes, seconds); end
    endtask

    task automatic test_mode12();
        do_reset(); mode12 = 1; #1;
        checks++; if (hours !== 5'd12 || pm !== 1'b0) begin failures++; $display("FAIL m12_midnight: got %0d pm=%0b expected 12/0", hours, pm); end
        repeat (2) step(0, 1, 0, 0, 0);
        repeat (13) step(0, 0, 1, 0, 0);
        checks++; if (hours !== 5'd1 || pm !== 1'b1) begin failures++; $display("FAIL m12_13h: got %0d pm=%0b expected 1/1", hours, pm); end
        step(0, 0, 0, 1, 0);
        checks++; if (hours !== 5'd12 || pm !== 1'b1) begin failures++; $display("FAIL m12_noon: got %0d pm=%0b expected 12/1", hours, pm); end
        repeat (11) step(0, 0, 0, 1, 0);
        checks++; if (hours !== 5'd1 || pm !== 1'b0) begin failures++; $display("FAIL m12_1am: got %0d pm=%0b expected 1/0", hours, pm); end
        mode12 = 0; #1;
        repeat (10) step(0, 0, 1, 0, 0);
        checks++; if (hours !== 5'd11 || pm !== 1'b0) begin failures++; $display("FAIL m24_11h: got %0d pm=%0b expected 11/0", hours, pm); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1, 1, 0, 0, 0);
        checks++; if (running !== 1'b1 || field !== 3'd0) begin failures++; $display("FAIL sim_sr_next: got run=%0b field=%0d expected 1/0", running, field); end
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        checks++; if (seconds !== 6'd1 || running !== 1'b0) begin failures++; $display("FAIL sim_inc_dec: got sec=%0d run=%0b expected 1/0", seconds, running); end
        step(0, 1, 1, 0, 0);
        checks++; if (field !== 3'd1 || seconds !== 6'd1 || minutes !== 6'd0) begin failures++; $display("FAIL sim_next_inc: got field=%0d sec=%0d min=%0d expected 1/1/0", field, seconds, minutes); end
        step(1, 0, 1, 0, 0);
        checks++; if (running !== 1'b1 || minutes !== 6'd0 || field !== 3'd1) begin failures++; $display("FAIL sim_sr_inc: got run=%0b min=%0d field=%0d expected 1/0/1", running, minutes, field); end
    endtask

    // Alarm 00:01, time 00:00:55, alarm enabled, then enter RUN
    task automatic alarm_setup();
        do_reset(); alarm_en = 0; mode12 = 0;
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 1, 0);
        alarm_en = 1;
        step(1, 0, 0, 0, 0);
    endtask

    task automatic test_alarm();
        logic exp_ring;
        // timeout after RING ticks
        alarm_setup();
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 0, 0);
            exp_ring = (k >= 5 && k <= 9);
            checks++; if (alarm_ring !== exp_ring) begin failures++; $display("FAIL ring_timeout k=%0d: got %0b expected %0b", k, alarm_ring, exp_ring); end
            if (k == 5) begin
                checks++; if ({alarm_minutes, minutes, seconds} !== {6'd1, 6'd1, 6'd0}) begin failures++; $display("FAIL ring_time: got %0d:%0d alarm_min=%0d expected 1:0 alarm_min=1", minutes, seconds, alarm_minutes); end
            end
        end
        // acknowledge on the second tick of ringing
        alarm_setup();
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 0, k == 7);
            exp_ring = (k >= 5 && k <= 6);
            checks++; if (alarm_ring !== exp_ring) begin failures++; $display("FAIL ring_ack k=%0d: got %0b expected %0b", k, alarm_ring, exp_ring); end
        end
        // alarm_en dropped while ringing
        alarm_setup();
        for (int k = 1; k <= 10; k++) begin
            if (k == 7) alarm_en = 0;
            step(0, 0, 0, 0, 0);
            exp_ring = (k >= 5 && k <= 6);
            checks++; if (alarm_ring !== exp_ring) begin failures++; $display("FAIL ring_en_low k=%0d: got %0b expected %0b", k, alarm_ring, exp_ring); end
        end
        // ringing survives SET with the counter frozen
        alarm_setup();
        repeat (5) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        checks++; if (alarm_ring !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL ring_in_set: got ring=%0b run=%0b expected 1/0", alarm_ring, running); end
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        checks++; if (alarm_ring !== 1'b1) begin failures++; $display("FAIL ring_resume: got %0b expected 1", alarm_ring); end
        step(0, 0, 0, 0, 0);
        checks++; if (alarm_ring !== 1'b0) begin failures++; $display("FAIL ring_resume_end: got %0b expected 0", alarm_ring); end
        // editing the time onto the alarm in SET does not ring
        do_reset(); alarm_en = 1;
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        checks++; if (alarm_ring !== 1'b0 || minutes !== 6'd1 || alarm_minutes !== 6'd1) begin failures++; $display("FAIL ring_set_edit: got ring=%0b min=%0d amin=%0d expected 0/1/1", alarm_ring, minutes, alarm_minutes); end
        step(0, 0, 0, 0, 1);
        checks++; if (alarm_ring !== 1'b0) begin failures++; $display("FAIL ack_idle: got %0b expected 0", alarm_ring); end
        alarm_en = 0;
    endtask

    task automatic test_prescaler();
        logic [5:0] exp_sec;
        do_reset(); mode12 = 0; alarm_en = 0;
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 0, 0, 0);
            exp_sec = 6'(k / 4);
            checks++; if (seconds_4 !== exp_sec) begin failures++; $display("FAIL prescale k=%0d: got %0d expected %0d", k, seconds_4, exp_sec); end
        end
        #2; rst = 1; #1;
        checks++; if ({hours_4, minutes_4, seconds_4, running_4, field_4, alarm_ring_4} !== 22'd0) begin failures++; $display("FAIL async_rst4: got %0d:%0d:%0d run=%0b field=%0d ring=%0b expected zeros", hours_4, minutes_4, seconds_4, running_4, field_4, alarm_ring_4); end
        checks++; if ({hours, minutes, seconds, running} !== 18'd0) begin failures++; $display("FAIL async_rst1: got %0d:%0d:%0d run=%0b expected zeros", hours, minutes, seconds, running); end
        model_reset();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_random();
        logic [33:0] exp_v, act_v;
        int h;
        int bad;
        bad = 0;
        do_reset(); alarm_en = 0;
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0);
        alarm_en = 1; mode12 = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(0, 59) == 0)  mode12 = ~mode12;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 29) == 0);
            h = m_tod / 3600;
            exp_v = {5'(disp_h(h, mode12)), 6'((m_tod / 60) % 60), 6'(m_tod % 60), h >= 12,
                     5'(m_al / 60), 6'(m_al % 60), m_ring != 0, m_run, 3'(m_field)};
            act_v = {hours, minutes, seconds, pm, alarm_hours, alarm_minutes, alarm_ring, running, field};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                if (bad < 10) $display("FAIL random cycle %0d: got %h expected %h", i, act_v, exp_v);
                bad++;
            end
        end
        alarm_en = 0; mode12 = 0;
    endtask

    // Safety net so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_count_carry();
        test_edit_wrap();
        test_mode12();
        test_simultaneous();
        test_alarm();
        test_prescaler();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hms_alarm_watch.md
Name: hms_alarm_watch

Overview:
- Parametrised successor to the team's hours/minutes/seconds watch core.
- Adds a configurable tick prescaler, 12/24-hour display mode, and a settable alarm with timed ring and acknowledge.
- Driven by the same four user pulses as the existing watch (stop_run, next, inc, dec); sits between the debounced button layer and the display driver.

Parameters:
- TICKS_PER_SEC, 1, clk cycles per second tick (>=1).
- RING_SECS, 60, seconds alarm_ring stays high if not acknowledged (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- stop_run  in  1  one-cycle pulse; toggles RUN/SET.
- next  in  1  one-cycle pulse; advances edit field (SET only).
- inc  in  1  one-cycle pulse; increments selected field (SET only).
- dec  in  1  one-cycle pulse; decrements selected field (SET only).
- mode12  in  1  level; 1 = 12-hour display.
- alarm_en  in  1  level; enables alarm compare and ring.
- alarm_ack  in  1  one-cycle pulse; clears alarm_ring.
- hours  out  5  displayed hour (0-23, or 1-12 when mode12).
- minutes  out  6  0-59.
- seconds  out  6  0-59.
- pm  out  1  1 when internal hour >= 12 (valid in both modes).
- alarm_hours  out  5  alarm hour, 0-23 (always 24h format).
- alarm_minutes  out  6  0-59.
- alarm_ring  out  1  alarm active.
- running  out  1  1 in RUN.
- field  out  3  edit field: 0=SEC, 1=MIN, 2=HR, 3=AMIN, 4=AHR.

Behaviour:
- Reset (async):
  - Time and alarm are 00:00:00 / 00:00.
  - State = SET, field = SEC, prescaler = 0, alarm_ring = 0, ring counter = 0.
  - Displayed hours = 0 when mode12=0; 12 when mode12=1. pm = 0.
- FSM has two states, SET and RUN. A stop_run pulse toggles state. Each entry to RUN clears the prescaler; field is retained.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1.
  - The tick fires on the cycle the count equals TICKS_PER_SEC-1. With the default of 1, every cycle is a tick.
  - First seconds increment occurs TICKS_PER_SEC cycles after the stop_run pulse cycle.
  - On tick: seconds+1. 59 wraps to 0 with carry to minutes; minutes 59 wraps to 0 with carry to hours; hours 23 wraps to 0.
  - next/inc/dec are ignored.
- SET:
  - Time is frozen.
  - next advances field 0->1->2->3->4->0.
  - inc/dec modify only the selected field, wrapping within its range (SEC/MIN/AMIN 0..59, HR/AHR 0..23) with no carry.
  - Editing SEC does not touch the prescaler.
- Simultaneous pulses in the same cycle:
  - stop_run takes priority; next/inc/dec in that cycle are dropped.
  - next beats inc/dec.
  - inc and dec together produce no change.
- Display conversion (combinational from internal 24h hour):
  - mode12=1: 0->12, 1..12 unchanged, 13..23 -> h-12.
  - pm = (hour >= 12).
- Alarm:
  - Trigger: in RUN, on the tick that makes time == alarm_hours:alarm_minutes:00 while alarm_en=1. alarm_ring rises on the cycle after that tick and the ring counter loads 0.
  - The ring counter increments on each tick while ringing.
  - alarm_ring clears on the earliest of: alarm_ack pulse, alarm_en low, or ring counter reaching RING_SECS.
  - Ringing continues across a RUN->SET transition (counter frozen in SET).
  - A trigger while already ringing restarts the counter.
  - Time edited to match in SET does not trigger.
  - alarm_ack when not ringing has no effect.
- Reset mid-operation: immediately returns all state to reset values, including clearing alarm_ring.

Test Plan:
- Count and carry: TICKS_PER_SEC=1. Reset, stop_run, run 3661 cycles -> 01:01:01, running=1; stop_run -> values hold for 20 cycles.
- Edit wrap: in SET field=SEC at 0, dec -> 59 and minutes unchanged; next twice, 5x inc from hours 21 -> hours 2 (wrap 23->0).
- 12-hour mode: set hours 0 -> with mode12=1, hours=12 and pm=0; set 13 -> hours=1, pm=1; set 12 -> hours=12, pm=1.
- Simultaneous pulses: stop_run+next in SET -> state RUN, field unchanged; inc+dec -> no change; next+inc -> field advances, value unchanged.
- Alarm ring and timeout: alarm 00:01, alarm_en=1, RING_SECS=5, run from 00:00:55. alarm_ring rises the cycle after 00:01:00, stays 5 ticks, clears. Repeat with alarm_ack at 2nd tick -> clears the next cycle.
- Prescaler: TICKS_PER_SEC=4, stop_run at cycle N -> seconds=1 at N+4, 2 at N+8. Async rst asserted mid-second -> all outputs zero immediately.
